// File: rtl/branch_resolve_unit.sv
// Branch reservation station: holds conditional branches until operands arrive, resolves them, and hands results out over valid/ready.
// Optional BRU_STATS_EN adds saturating resolved/mispredict counters.
module branch_resolve_unit #(
  parameter int RS_DEPTH = 4,
  parameter int TAG_W    = 4,
  parameter int XLEN     = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             flush_in,
  input  logic             issue_valid_in,
  output logic             issue_ready_out,
  input  logic [2:0]       issue_brfunc_in,
  input  logic [XLEN-1:0]  issue_pc_in,
  input  logic [XLEN-1:0]  issue_imm_in,
  input  logic             issue_pred_taken_in,
  input  logic [TAG_W-1:0] issue_rob_tag_in,
  input  logic             issue_src1_rdy_in,
  input  logic [TAG_W-1:0] issue_src1_tag_in,
  input  logic [XLEN-1:0]  issue_src1_val_in,
  input  logic             issue_src2_rdy_in,
  input  logic [TAG_W-1:0] issue_src2_tag_in,
  input  logic [XLEN-1:0]  issue_src2_val_in,
  input  logic             cdb_valid_in,
  input  logic [TAG_W-1:0] cdb_tag_in,
  input  logic [XLEN-1:0]  cdb_value_in,
  output logic             res_valid_out,
  input  logic             res_ready_in,
  output logic [TAG_W-1:0] res_rob_tag_out,
  output logic             res_taken_out,
  output logic [XLEN-1:0]  res_target_out,
  output logic             res_mispredict_out
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]      stat_resolved_out,
  output logic [31:0]      stat_mispredict_out
`endif
);

  localparam int IDXW = $clog2(RS_DEPTH);
  localparam int CNTW = $clog2(RS_DEPTH + 1);

  typedef struct packed {
    logic [2:0]       func;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic             pred;
    logic [TAG_W-1:0] rob_tag;
    logic             s1_rdy;
    logic [TAG_W-1:0] s1_tag;
    logic [XLEN-1:0]  s1_val;
    logic             s2_rdy;
    logic [TAG_W-1:0] s2_tag;
    logic [XLEN-1:0]  s2_val;
  } entry_t;

  entry_t              ent_q [RS_DEPTH];
  entry_t              ent_d [RS_DEPTH];
  entry_t              snp   [RS_DEPTH];
  entry_t              new_ent;
  logic [RS_DEPTH-1:0] vld_q, vld_d;
  logic [CNTW-1:0]     cnt, slot;
  logic [IDXW-1:0]     fire_idx;
  logic                fire_found, fire_en, issue_fire;

  logic                res_valid_q, res_valid_d, res_taken_q, res_taken_d, res_mp_q, res_mp_d;
  logic [TAG_W-1:0]    res_tag_q, res_tag_d;
  logic [XLEN-1:0]     res_target_q, res_target_d;

  function automatic logic br_taken(input logic [2:0] f,
                                    input logic signed [XLEN-1:0] a,
                                    input logic signed [XLEN-1:0] b);
    logic t;
    t = 1'b0;
    case (f)
      3'd0:    t = (a == b);
      3'd1:    t = (a != b);
      3'd2:    t = (a < b);
      3'd3:    t = ($unsigned(a) < $unsigned(b));
      3'd4:    t = (a >= b);
      3'd5:    t = ($unsigned(a) >= $unsigned(b));
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic [XLEN-1:0] br_target(input logic [XLEN-1:0] pc,
                                                input logic [XLEN-1:0] imm,
                                                input logic taken);
    return taken ? (pc + imm) : (pc + XLEN'(32'd4));
  endfunction

  assign issue_ready_out = ~&vld_q;
  assign issue_fire      = issue_valid_in && issue_ready_out;

  // Select: oldest entry whose operands were ready at the start of the cycle
  always_comb begin
    fire_found = 1'b0;
    fire_idx   = '0;
    cnt        = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (vld_q[i] && ent_q[i].s1_rdy && ent_q[i].s2_rdy) begin
        fire_found = 1'b1;
        fire_idx   = IDXW'(i);
      end
    end
    for (int i = 0; i < RS_DEPTH; i++) cnt = cnt + CNTW'(vld_q[i]);
    fire_en = fire_found && (!res_valid_q || res_ready_in);
    slot    = cnt - CNTW'(fire_en);
  end

  // Queue update: CDB snoop, compaction on fire, then insert behind the survivors
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      snp[i] = ent_q[i];
      if (cdb_valid_in && !snp[i].s1_rdy && snp[i].s1_tag == cdb_tag_in) begin
        snp[i].s1_rdy = 1'b1;
        snp[i].s1_val = cdb_value_in;
      end
      if (cdb_valid_in && !snp[i].s2_rdy && snp[i].s2_tag == cdb_tag_in) begin
        snp[i].s2_rdy = 1'b1;
        snp[i].s2_val = cdb_value_in;
      end
    end

    new_ent.func    = issue_brfunc_in;
    new_ent.pc      = issue_pc_in;
    new_ent.imm     = issue_imm_in;
    new_ent.pred    = issue_pred_taken_in;
    new_ent.rob_tag = issue_rob_tag_in;
    new_ent.s1_rdy  = issue_src1_rdy_in;
    new_ent.s1_tag  = issue_src1_tag_in;
    new_ent.s1_val  = issue_src1_val_in;
    new_ent.s2_rdy  = issue_src2_rdy_in;
    new_ent.s2_tag  = issue_src2_tag_in;
    new_ent.s2_val  = issue_src2_val_in;
    if (cdb_valid_in && !issue_src1_rdy_in && issue_src1_tag_in == cdb_tag_in) begin
      new_ent.s1_rdy = 1'b1;
      new_ent.s1_val = cdb_value_in;
    end
    if (cdb_valid_in && !issue_src2_rdy_in && issue_src2_tag_in == cdb_tag_in) begin
      new_ent.s2_rdy = 1'b1;
      new_ent.s2_val = cdb_value_in;
    end

    for (int i = 0; i < RS_DEPTH; i++) ent_d[i] = snp[i];
    vld_d = vld_q;
    if (fire_en) begin
      for (int i = 0; i < RS_DEPTH - 1; i++) begin
        if (IDXW'(i) >= fire_idx) begin
          ent_d[i] = snp[i+1];
          vld_d[i] = vld_q[i+1];
        end
      end
      vld_d[RS_DEPTH-1] = 1'b0;
    end
    if (issue_fire) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (CNTW'(i) == slot) begin
          ent_d[i] = new_ent;
          vld_d[i] = 1'b1;
        end
      end
    end
    if (flush_in) vld_d = '0;
  end

  // Resolve stage: evaluate the fired entry into the output register
  always_comb begin
    res_valid_d  = res_valid_q;
    res_tag_d    = res_tag_q;
    res_taken_d  = res_taken_q;
    res_target_d = res_target_q;
    res_mp_d     = res_mp_q;
    if (res_valid_q && res_ready_in) res_valid_d = 1'b0;
    if (fire_en) begin
      res_valid_d  = 1'b1;
      res_tag_d    = ent_q[fire_idx].rob_tag;
      res_taken_d  = br_taken(ent_q[fire_idx].func, ent_q[fire_idx].s1_val, ent_q[fire_idx].s2_val);
      res_target_d = br_target(ent_q[fire_idx].pc, ent_q[fire_idx].imm, res_taken_d);
      res_mp_d     = res_taken_d != ent_q[fire_idx].pred;
    end
    if (flush_in) res_valid_d = 1'b0;
  end

  always_ff @(posedge clk_in) begin
    for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= ent_d[i];
    if (rst_in) begin
      vld_q        <= '0;
      res_valid_q  <= 1'b0;
      res_tag_q    <= '0;
      res_taken_q  <= 1'b0;
      res_target_q <= '0;
      res_mp_q     <= 1'b0;
    end else begin
      vld_q        <= vld_d;
      res_valid_q  <= res_valid_d;
      res_tag_q    <= res_tag_d;
      res_taken_q  <= res_taken_d;
      res_target_q <= res_target_d;
      res_mp_q     <= res_mp_d;
    end
  end

  assign res_valid_out      = res_valid_q;
  assign res_rob_tag_out    = res_tag_q;
  assign res_taken_out      = res_taken_q;
  assign res_target_out     = res_target_q;
  assign res_mispredict_out = res_mp_q;

`ifdef BRU_STATS_EN
  logic [31:0] stat_res_q, stat_res_d, stat_mp_q, stat_mp_d;

  always_comb begin
    stat_res_d = stat_res_q;
    stat_mp_d  = stat_mp_q;
    if (res_valid_q && res_ready_in) begin
      if (stat_res_q != 32'hFFFF_FFFF) stat_res_d = stat_res_q + 32'd1;
      if (res_mp_q && stat_mp_q != 32'hFFFF_FFFF) stat_mp_d = stat_mp_q + 32'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stat_res_q <= '0;
      stat_mp_q  <= '0;
    end else begin
      stat_res_q <= stat_res_d;
      stat_mp_q  <= stat_mp_d;
    end
  end

  assign stat_resolved_out   = stat_res_q;
  assign stat_mispredict_out = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: compare/target table, CDB wakeup, age order, backpressure, flush.
module tb_branch_resolve_unit;
  logic        clk = 1'b0;
  logic        rst, flush, issue_valid, issue_ready, pred;
  logic [2:0]  func;
  logic [31:0] pc, imm, v1, v2, cdb_val, res_target;
  logic [3:0]  rob_tag, t1, t2, cdb_tag, res_tag;
  logic        r1, r2, cdb_valid, res_valid, res_ready, res_taken, res_mp;
`ifdef BRU_STATS_EN
  logic [31:0] stat_res, stat_mp;
`endif
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.RS_DEPTH(4), .TAG_W(4), .XLEN(32)) dut (
    .clk_in(clk), .rst_in(rst), .flush_in(flush),
    .issue_valid_in(issue_valid), .issue_ready_out(issue_ready),
    .issue_brfunc_in(func), .issue_pc_in(pc), .issue_imm_in(imm),
    .issue_pred_taken_in(pred), .issue_rob_tag_in(rob_tag),
    .issue_src1_rdy_in(r1), .issue_src1_tag_in(t1), .issue_src1_val_in(v1),
    .issue_src2_rdy_in(r2), .issue_src2_tag_in(t2), .issue_src2_val_in(v2),
    .cdb_valid_in(cdb_valid), .cdb_tag_in(cdb_tag), .cdb_value_in(cdb_val),
    .res_valid_out(res_valid), .res_ready_in(res_ready),
    .res_rob_tag_out(res_tag), .res_taken_out(res_taken),
    .res_target_out(res_target), .res_mispredict_out(res_mp)
`ifdef BRU_STATS_EN
    , .stat_resolved_out(stat_res), .stat_mispredict_out(stat_mp)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [2:0] f, input logic [31:0] p, input logic [31:0] im,
                          input logic pr, input logic [3:0] rt,
                          input logic a_rdy, input logic [3:0] a_tag, input logic [31:0] a_val,
                          input logic b_rdy, input logic [3:0] b_tag, input logic [31:0] b_val);
    issue_valid = 1'b1; func = f; pc = p; imm = im; pred = pr; rob_tag = rt;
    r1 = a_rdy; t1 = a_tag; v1 = a_val; r2 = b_rdy; t2 = b_tag; v2 = b_val;
    step();
    issue_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", res_valid); end
    total++; if (res_tag !== 4'd0) begin bad++; $display("FAIL reset_tag got=%0d want=0", res_tag); end
    total++; if (res_taken !== 1'b0) begin bad++; $display("FAIL reset_taken got=%0b want=0", res_taken); end
    total++; if (res_target !== 32'd0) begin bad++; $display("FAIL reset_target got=%h want=0", res_target); end
    total++; if (res_mp !== 1'b0) begin bad++; $display("FAIL reset_mp got=%0b want=0", res_mp); end
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", issue_ready); end
  endtask

  logic [2:0]  c_f  [11];
  logic [31:0] c_a  [11];
  logic [31:0] c_b  [11];
  logic [31:0] c_pc [11];
  logic [31:0] c_im [11];
  logic        c_pr [11];
  logic        c_tk [11];
  logic [31:0] c_tg [11];
  logic        c_mp [11];

  task automatic test_compare();
    c_f  = '{3'd2, 3'd3, 3'd5, 3'd4, 3'd0, 3'd1, 3'd6, 3'd7, 3'd0, 3'd2, 3'd3};
    c_a  = '{32'hFFFFFFFB, 32'hFFFFFFFB, 32'hC, 32'hC, 32'h7, 32'h7, 32'h5, 32'h0, 32'h1, 32'h80000000, 32'h80000000};
    c_b  = '{32'hA, 32'hA, 32'hFFFFFFF6, 32'hFFFFFFF6, 32'h7, 32'h7, 32'h5, 32'h0, 32'h1, 32'h7FFFFFFF, 32'h7FFFFFFF};
    c_pc = '{32'h100, 32'h200, 32'h300, 32'h300, 32'h400, 32'h400, 32'h500, 32'h500, 32'hFFFFFFF0, 32'h600, 32'h600};
    c_im = '{32'h20, 32'h40, 32'h10, 32'h10, 32'hFFFFFFF0, 32'h8, 32'h80, 32'h80, 32'h20, 32'h8, 32'h8};
    c_pr = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    c_tk = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    c_tg = '{32'h120, 32'h204, 32'h304, 32'h310, 32'h3F0, 32'h404, 32'h504, 32'h504, 32'h10, 32'h608, 32'h604};
    c_mp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    res_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      do_issue(c_f[i], c_pc[i], c_im[i], c_pr[i], 4'(i), 1'b1, 4'd0, c_a[i], 1'b1, 4'd0, c_b[i]);
      total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL cmp%0d_early_valid got=%0b want=0", i, res_valid); end
      step();
      total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL cmp%0d_valid got=%0b want=1", i, res_valid); end
      total++; if (res_tag !== 4'(i)) begin bad++; $display("FAIL cmp%0d_tag got=%0d want=%0d", i, res_tag, i); end
      total++; if (res_taken !== c_tk[i]) begin bad++; $display("FAIL cmp%0d_taken got=%0b want=%0b", i, res_taken, c_tk[i]); end
      total++; if (res_target !== c_tg[i]) begin bad++; $display("FAIL cmp%0d_target got=%h want=%h", i, res_target, c_tg[i]); end
      total++; if (res_mp !== c_mp[i]) begin bad++; $display("FAIL cmp%0d_mp got=%0b want=%0b", i, res_mp, c_mp[i]); end
    end
    step();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL cmp_drain got=%0b want=0", res_valid); end
  endtask

  task automatic test_cdb_wakeup();
    res_ready = 1'b1;
    do_issue(3'd0, 32'h700, 32'h10, 1'b1, 4'd5, 1'b1, 4'd0, 32'd12, 1'b0, 4'd3, 32'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL wait%0d_valid got=%0b want=0", k, res_valid); end
    end
    cdb_valid = 1'b1; cdb_tag = 4'd4; cdb_val = 32'd12;
    step();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL wrongtag_valid got=%0b want=0", res_valid); end
    cdb_tag = 4'd3;
    step();
    cdb_valid = 1'b0;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL capture_valid got=%0b want=0", res_valid); end
    step();
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL wake_valid got=%0b want=1", res_valid); end
    total++; if (res_taken !== 1'b1) begin bad++; $display("FAIL wake_taken got=%0b want=1", res_taken); end
    total++; if (res_target !== 32'h710) begin bad++; $display("FAIL wake_target got=%h want=710", res_target); end
    total++; if (res_mp !== 1'b0) begin bad++; $display("FAIL wake_mp got=%0b want=0", res_mp); end
    step();
    cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_val = 32'd12;
    do_issue(3'd0, 32'h700, 32'h10, 1'b1, 4'd6, 1'b1, 4'd0, 32'd12, 1'b0, 4'd3, 32'd0);
    cdb_valid = 1'b0;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL bypass_early got=%0b want=0", res_valid); end
    step();
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL bypass_valid got=%0b want=1", res_valid); end
    total++; if (res_tag !== 4'd6) begin bad++; $display("FAIL bypass_tag got=%0d want=6", res_tag); end
    total++; if (res_taken !== 1'b1) begin bad++; $display("FAIL bypass_taken got=%0b want=1", res_taken); end
    step();
    do_issue(3'd0, 32'h800, 32'h4, 1'b0, 4'd7, 1'b0, 4'd5, 32'd0, 1'b1, 4'd0, 32'd9);
    cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_val = 32'd9;
    step();
    cdb_valid = 1'b0;
    step();
    total++; if (res_valid !== 1'b1 || res_tag !== 4'd7) begin bad++; $display("FAIL src1wake got=%0b/%0d want=1/7", res_valid, res_tag); end
    total++; if (res_taken !== 1'b1) begin bad++; $display("FAIL src1wake_taken got=%0b want=1", res_taken); end
    step();
  endtask

  task automatic test_order_backpressure();
    logic [3:0] exp_tag [3];
    exp_tag = '{4'd10, 4'd11, 4'd13};
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      do_issue(3'd0, 32'h1000 + 32'(16 * k), 32'h8, 1'b0, 4'(10 + k), 1'b1, 4'd0, 32'd1, 1'b0, 4'(8 + k), 32'd0);
      if (k == 2) begin
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL three_ready got=%0b want=1", issue_ready); end
      end
    end
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%0b want=0", issue_ready); end
    cdb_valid = 1'b1; cdb_tag = 4'd10; cdb_val = 32'd1;
    step();
    cdb_valid = 1'b0;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL e2_early got=%0b want=0", res_valid); end
    step();
    total++; if (res_valid !== 1'b1 || res_tag !== 4'd12) begin bad++; $display("FAIL e2_first got=%0b/%0d want=1/12", res_valid, res_tag); end
    total++; if (res_target !== 32'h1028) begin bad++; $display("FAIL e2_target got=%h want=1028", res_target); end
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL e2_ready got=%0b want=1", issue_ready); end
    res_ready = 1'b0;
    cdb_valid = 1'b1;
    cdb_tag = 4'd8;  step();
    cdb_tag = 4'd9;  step();
    cdb_tag = 4'd11; step();
    cdb_valid = 1'b0;
    step();
    step();
    total++; if (res_valid !== 1'b1 || res_tag !== 4'd12) begin bad++; $display("FAIL hold_tag got=%0b/%0d want=1/12", res_valid, res_tag); end
    total++; if (res_target !== 32'h1028) begin bad++; $display("FAIL hold_target got=%h want=1028", res_target); end
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL hold_ready got=%0b want=1", issue_ready); end
    res_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (res_valid !== 1'b1 || res_tag !== exp_tag[k]) begin bad++; $display("FAIL age%0d got=%0b/%0d want=1/%0d", k, res_valid, res_tag, exp_tag[k]); end
    end
    step();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL age_drain got=%0b want=0", res_valid); end
  endtask

  task automatic test_flush();
    res_ready = 1'b0;
    do_issue(3'd0, 32'h900, 32'h4, 1'b0, 4'd1, 1'b1, 4'd0, 32'd3, 1'b1, 4'd0, 32'd3);
    do_issue(3'd0, 32'h910, 32'h4, 1'b0, 4'd2, 1'b1, 4'd0, 32'd3, 1'b0, 4'd6, 32'd0);
    do_issue(3'd0, 32'h920, 32'h4, 1'b0, 4'd3, 1'b1, 4'd0, 32'd3, 1'b0, 4'd7, 32'd0);
    total++; if (res_valid !== 1'b1 || res_tag !== 4'd1) begin bad++; $display("FAIL preflush got=%0b/%0d want=1/1", res_valid, res_tag); end
    flush = 1'b1;
    do_issue(3'd0, 32'h930, 32'h4, 1'b0, 4'd4, 1'b1, 4'd0, 32'd3, 1'b1, 4'd0, 32'd3);
    flush = 1'b0;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b want=0", res_valid); end
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%0b want=1", issue_ready); end
    res_ready = 1'b1;
    cdb_valid = 1'b1; cdb_val = 32'd3;
    for (int k = 0; k < 4; k++) begin
      cdb_tag = 4'(6 + (k % 2));
      if (k == 2) cdb_valid = 1'b0;
      step();
      total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL stale%0d got=%0b want=0", k, res_valid); end
    end
    for (int k = 0; k < 4; k++) begin
      do_issue(3'd1, 32'hA00, 32'h4, 1'b0, 4'(k), 1'b0, 4'd15, 32'd0, 1'b1, 4'd0, 32'd0);
      if (k == 2) begin
        total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL refill3 got=%0b want=1", issue_ready); end
      end
    end
    total++; if (issue_ready !== 1'b0) begin bad++; $display("FAIL refill4 got=%0b want=0", issue_ready); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++; if (issue_ready !== 1'b1) begin bad++; $display("FAIL reflush got=%0b want=1", issue_ready); end
  endtask

`ifdef BRU_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    step();
    rst = 1'b0;
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      do_issue(3'd0, 32'hB00, 32'h4, (k < 3), 4'(k), 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1);
      step();
    end
    step();
    total++; if (stat_res !== 32'd5) begin bad++; $display("FAIL stat_res got=%0d want=5", stat_res); end
    total++; if (stat_mp !== 32'd2) begin bad++; $display("FAIL stat_mp got=%0d want=2", stat_mp); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++; if (stat_res !== 32'd5 || stat_mp !== 32'd2) begin bad++; $display("FAIL stat_flush got=%0d/%0d want=5/2", stat_res, stat_mp); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if (stat_res !== 32'd0 || stat_mp !== 32'd0) begin bad++; $display("FAIL stat_rst got=%0d/%0d want=0/0", stat_res, stat_mp); end
  endtask
`endif

  initial begin
    rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; func = 3'd0; pc = '0; imm = '0; pred = 1'b0;
    rob_tag = '0; r1 = 1'b0; t1 = '0; v1 = '0; r2 = 1'b0; t2 = '0; v2 = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_val = '0; res_ready = 1'b1;
    test_reset();
    test_compare();
    test_cdb_wakeup();
    test_order_backpressure();
    test_flush();
`ifdef BRU_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Branch functional unit for the out-of-order core: a small reservation station that holds issued conditional branches until both source operands arrive. It snoops the common data bus (CDB) for missing operands. It evaluates the branch condition and target internally, then hands a resolved result to the ROB/fetch-redirect logic over a valid/ready handshake. It sits between the issue stage (producer side) and the ROB/fetch redirect path (consumer side).

Parameters:
RS_DEPTH, 4, number of reservation-station entries (2..8)
TAG_W, 4, ROB tag width
XLEN, 32, operand/PC width

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous active-high reset
flush_in  input  1  misprediction flush; clears all state
issue_valid_in  input  1  issue request
issue_ready_out  output  1  a free entry exists
issue_brfunc_in  input  3  Eq=0 Neq=1 Lt=2 Ltu=3 Ge=4 Geu=5 Dbr=6; 7 treated as Dbr
issue_pc_in  input  XLEN  branch PC
issue_imm_in  input  XLEN  sign-extended branch offset
issue_pred_taken_in  input  1  fetch prediction
issue_rob_tag_in  input  TAG_W  ROB tag of the branch
issue_src1_rdy_in  input  1  src1 value valid
issue_src1_tag_in  input  TAG_W  producer tag if not ready
issue_src1_val_in  input  XLEN  src1 value if ready
issue_src2_rdy_in / issue_src2_tag_in / issue_src2_val_in  input  1/TAG_W/XLEN  same for src2
cdb_valid_in  input  1  CDB broadcast valid
cdb_tag_in  input  TAG_W  CDB producer tag
cdb_value_in  input  XLEN  CDB value
res_valid_out  output  1  resolved result valid
res_ready_in  input  1  consumer accepts result
res_rob_tag_out  output  TAG_W  tag of resolved branch
res_taken_out  output  1  condition outcome
res_target_out  output  XLEN  pc+imm if taken, else pc+4
res_mispredict_out  output  1  res_taken_out != predicted

Behaviour:
- Reset (rst_in=1 at posedge): all entries invalid; res_valid_out=0; res_rob_tag_out, res_taken_out, res_target_out, res_mispredict_out =0; issue_ready_out=1 after reset.
- issue_ready_out = 1 iff at least one entry is invalid. The output is combinational from entry state only, not from issue_valid_in.
- Issue accepted when issue_valid_in && issue_ready_out. The branch is written into the lowest free slot in age order (compacting queue; index 0 = oldest).
- CDB snoop: each valid entry with srcN not ready and tag == cdb_tag_in captures the value and sets ready that cycle.
- Same-cycle bypass: if an issuing op's srcN is not ready and cdb_valid_in with a matching tag, it is stored ready with cdb_value_in.
- Select: the oldest entry with both sources ready fires when the output register is empty or is being drained (res_valid_out && res_ready_in) in the same cycle. The fired entry is removed and the younger entries shift down one slot.
- A removal and an issue in the same cycle are both honoured. A full queue accepts an issue in the cycle an entry fires only on the next cycle (issue_ready_out is registered from the pre-fire state).
- Latency: the earliest fire is the cycle after the operands become ready. An issue with both sources ready produces res_valid_out 2 cycles after the issue handshake.
- Compare: signed for Lt/Ge, unsigned for Ltu/Geu, equality for Eq/Neq; Dbr (and 7) gives taken=0.
- Target: XLEN-bit add with wrap-around; no overflow detection.
- Output register holds its value stable while res_valid_out && !res_ready_in.
- flush_in: at posedge, clears all entries and res_valid_out. Flush has priority over issue, CDB capture and fire in that cycle.
- rst_in has priority over flush_in.

Optional Feature:
BRU_STATS_EN: when defined, adds output ports stat_resolved_out[31:0] and stat_mispredict_out[31:0].
- Both counters increment on each result handshake (res_valid_out && res_ready_in); stat_mispredict_out increments only when res_mispredict_out=1.
- Counters saturate at 32'hFFFFFFFF, clear on rst_in, and are unaffected by flush_in.
- When undefined, neither the ports nor the counters exist.

Test Plan:
- Issue Lt, src1=-5, src2=10 both ready, pc=0x100, imm=0x20, pred=0, res_ready_in=1 -> 2 cycles later res_valid_out=1, taken=1, target=0x120, mispredict=1.
- Issue Ltu, src1=-5 (0xFFFFFFFB), src2=10 -> taken=0, target=pc+4; Geu 12 vs -10 -> taken=0; Ge 12 vs -10 -> taken=1.
- Issue Eq with src2 waiting on tag 3; drive CDB tag 3 value 12 with src1=12 -> no result before the CDB cycle; result taken=1 one cycle after capture. Repeat with the CDB in the issue cycle (bypass) -> same timing.
- Fill all 4 entries unready -> issue_ready_out=0; broadcast the tag of entry 2 only -> entry 2 resolves first. Then ready all -> results in age order. Hold res_ready_in=0 -> output stable and no further fires.
- Issue 3 entries, assert flush_in with res_valid_out=1 -> next cycle res_valid_out=0, issue_ready_out=1; a stale CDB tag afterwards produces no result.
- Dbr with any operands -> taken=0, target=pc+4. With BRU_STATS_EN, after 5 handshakes of which 2 mispredict -> stat_resolved_out=5, stat_mispredict_out=2; the counts survive flush_in and clear on rst_in.
